// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues word fetches to imem and
// buffers in-order responses with their PCs for the decode stage.
module fetch_queue #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [AWIDTH-1:0] dec_pc_o,
    output logic [DWIDTH-1:0] dec_insn_o
);

    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]       DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(4);

    logic [AWIDTH-1:0] req_pc_q, req_pc_d;
    logic [AWIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              started_q;
    logic [AWIDTH-1:0] dec_pc_q, dec_pc_d;
    logic [DWIDTH-1:0] dec_insn_q, dec_insn_d;
    logic [AWIDTH-1:0] mem_pc_q   [DEPTH];
    logic [DWIDTH-1:0] mem_insn_q [DEPTH];

    logic [CW:0]       credit_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              pop_s;
    logic              enq_s;
    logic [CW-1:0]     count_mid_s;

    // Handshake decode and next-state for PC, queue and in-flight accounting
    always_comb begin
        credit_s    = {1'b0, outst_q} + {1'b0, count_q};
        req_valid_s = started_q && !redirect_i && (credit_s < DEPTH_W);
        req_fire_s  = req_valid_s && imem_req_ready_i;
        pop_s       = (count_q != '0) && dec_ready_i;
        enq_s       = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
        count_mid_s = count_q - CW'(pop_s);

        req_pc_d   = req_pc_q;
        rsp_pc_d   = rsp_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        dec_pc_d   = dec_pc_q;
        dec_insn_d = dec_insn_q;

        if (redirect_i) begin
            // Every request still in flight after this edge belongs to the old stream.
            req_pc_d = {redirect_pc_i[AWIDTH-1:2], 2'b00};
            rsp_pc_d = {redirect_pc_i[AWIDTH-1:2], 2'b00};
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            outst_d  = outst_q - CW'(imem_rsp_valid_i);
            drop_d   = outst_q - CW'(imem_rsp_valid_i);
        end else begin
            if (req_fire_s) begin
                req_pc_d = req_pc_q + PC_STEP;
            end else begin
                req_pc_d = req_pc_q;
            end
            outst_d = outst_q + CW'(req_fire_s) - CW'(imem_rsp_valid_i);
            if (imem_rsp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1'b1);
            end else begin
                drop_d = drop_q;
            end
            if (enq_s) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
                tail_d   = tail_q + PW'(1'b1);
            end else begin
                rsp_pc_d = rsp_pc_q;
                tail_d   = tail_q;
            end
            head_d  = head_q + PW'(pop_s);
            count_d = count_mid_s + CW'(enq_s);
            // Head register follows the next head; an empty queue keeps the last popped entry.
            if (count_d != '0) begin
                if (count_mid_s == '0) begin
                    dec_pc_d   = rsp_pc_q;
                    dec_insn_d = imem_rsp_data_i;
                end else begin
                    dec_pc_d   = mem_pc_q[head_d];
                    dec_insn_d = mem_insn_q[head_d];
                end
            end else begin
                dec_pc_d   = dec_pc_q;
                dec_insn_d = dec_insn_q;
            end
        end
    end

    // State registers, queue storage and registered decode head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pc_q   <= BASEADDR;
            rsp_pc_q   <= BASEADDR;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            started_q  <= 1'b0;
            dec_pc_q   <= '0;
            dec_insn_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= '0;
                mem_insn_q[i] <= '0;
            end
        end else begin
            req_pc_q   <= req_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            started_q  <= 1'b1;
            dec_pc_q   <= dec_pc_d;
            dec_insn_q <= dec_insn_d;
            if (enq_s) begin
                mem_pc_q[tail_q]   <= rsp_pc_q;
                mem_insn_q[tail_q] <= imem_rsp_data_i;
            end
        end
    end

    assign imem_req_valid_o = req_valid_s;
    assign imem_req_addr_o  = req_pc_q;
    assign dec_valid_o      = (count_q != '0);
    assign dec_pc_o         = dec_pc_q;
    assign dec_insn_o       = dec_insn_q;

    a_outst_bound: assert property (@(posedge clk) disable iff (!rst_n)
        int'(outst_q) <= DEPTH);
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        int'(count_q) <= DEPTH);
    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop_q <= outst_q);
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid_i |-> (outst_q != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an imem model tags each fetch with a
// redirect epoch so decode can check PC continuity and data provenance.
module tb_fetch_queue;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_valid_o;
    logic          imem_req_ready_i;
    logic [AW-1:0] imem_req_addr_o;
    logic          imem_rsp_valid_i;
    logic [DW-1:0] imem_rsp_data_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          dec_valid_o;
    logic          dec_ready_i;
    logic [AW-1:0] dec_pc_o;
    logic [DW-1:0] dec_insn_o;

    fetch_queue #(
        .AWIDTH(AW), .DWIDTH(DW), .BASEADDR(BASE), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
        .imem_req_addr_o(imem_req_addr_o),
        .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_pc_o(dec_pc_o), .dec_insn_o(dec_insn_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          ep;
        int          due;
    } req_t;

    req_t        pending[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          queued   = 0;
    logic [31:0] req_pc_m = BASE;
    logic [31:0] exp_pc   = BASE;

    function automatic logic [31:0] mk_data(input logic [31:0] a, input int ep);
        return (a * 32'h9E37_79B1) ^ (32'(ep) * 32'h0101_0101);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        pending.delete();
        queued   = 0;
        req_pc_m = BASE;
        exp_pc   = BASE;
        epoch++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_valid"}, imem_req_valid_o, 32'd0);
        check_val({tag, "_dec_valid"}, dec_valid_o, 32'd0);
        check_val({tag, "_dec_pc"}, dec_pc_o, 32'd0);
        check_val({tag, "_dec_insn"}, dec_insn_o, 32'd0);
    endtask

    task automatic run_phase(input int ncyc, input int p_reqrdy, input int p_decrdy,
                             input int lat_max, input int p_redir,
                             input bit one_shot, input logic [31:0] shot_pc);
        bit          shot_done = 1'b0;
        bit          exp_rv;
        logic [31:0] tgt;
        req_t        r;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            imem_req_ready_i = ($urandom_range(0, 99) < p_reqrdy);
            dec_ready_i      = ($urandom_range(0, 99) < p_decrdy);
            tgt              = $urandom;
            redirect_i       = 1'b0;
            if (one_shot && !shot_done && pending.size() >= 2) begin
                redirect_i = 1'b1;
                tgt        = shot_pc;
                shot_done  = 1'b1;
            end else if ($urandom_range(0, 99) < p_redir) begin
                redirect_i = 1'b1;
            end
            redirect_pc_i    = tgt;
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
            if (pending.size() > 0 && pending[0].due <= cyc &&
                (lat_max == 0 || $urandom_range(0, 3) != 0)) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = pending[0].data;
            end
            @(negedge clk);
            exp_rv = !redirect_i && (pending.size() + queued < DEPTH);
            check_val("req_valid", imem_req_valid_o, exp_rv);
            if (imem_req_valid_o) check_val("req_addr", imem_req_addr_o, req_pc_m);
            check_val("dec_valid", dec_valid_o, queued > 0);
            if (dec_valid_o && dec_ready_i && !redirect_i) begin
                check_val("dec_pc", dec_pc_o, exp_pc);
                check_val("dec_insn", dec_insn_o, mk_data(exp_pc, epoch));
                exp_pc = exp_pc + 32'd4;
                queued--;
            end
            if (imem_rsp_valid_i) begin
                r = pending.pop_front();
                if (!redirect_i && r.ep == epoch) queued++;
            end
            if (imem_req_valid_o && imem_req_ready_i) begin
                r.addr = req_pc_m;
                r.data = mk_data(req_pc_m, epoch);
                r.ep   = epoch;
                r.due  = cyc + 1 + int'($urandom_range(0, lat_max));
                pending.push_back(r);
                req_pc_m = req_pc_m + 32'd4;
            end
            if (redirect_i) begin
                epoch++;
                req_pc_m = {tgt[31:2], 2'b00};
                exp_pc   = {tgt[31:2], 2'b00};
                queued   = 0;
            end
        end
        if (one_shot) check_val("shot_redirect_taken", shot_done, 32'd1);
    endtask

    initial begin
        rst_n            = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'd0;
        redirect_i       = 1'b0;
        redirect_pc_i    = 32'd0;
        dec_ready_i      = 1'b0;
        #1;
        check_reset_outputs("por");
        #21;
        rst_n = 1'b1;
        #1;
        check_val("req_valid_before_edge", imem_req_valid_o, 32'd0);

        run_phase(30, 100, 100, 0, 0, 1'b0, 32'd0);
        run_phase(10, 100, 0, 0, 0, 1'b0, 32'd0);
        run_phase(20, 100, 100, 0, 0, 1'b0, 32'd0);
        run_phase(3, 0, 100, 0, 0, 1'b0, 32'd0);
        run_phase(20, 100, 100, 0, 0, 1'b0, 32'd0);
        run_phase(60, 100, 100, 3, 0, 1'b1, 32'h0100_0103);
        run_phase(2000, 70, 60, 3, 4, 1'b0, 32'd0);

        // Asynchronous reset in the middle of traffic
        #2;
        rst_n            = 1'b0;
        imem_rsp_valid_i = 1'b0;
        redirect_i       = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("req_valid_after_release", imem_req_valid_o, 32'd0);
        check_val("req_addr_after_release", imem_req_addr_o, BASE);

        run_phase(30, 100, 100, 0, 0, 1'b0, 32'd0);
        run_phase(1000, 80, 70, 2, 3, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
